// File: rtl/od_pad_pkg.sv
// rtl/od_pad_pkg.sv - shared parameter defaults, legal ranges and helpers for the open-drain pad bank
package od_pad_pkg;

    // Parameter defaults
    localparam int N_CH_DEF        = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 3;
    localparam int SETTLE_CYC_DEF  = 4;

    // Legal ranges
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILT_LEN_MIN    = 1;
    localparam int FILT_LEN_MAX    = 15;
    localparam int SETTLE_CYC_MIN  = 0;
    localparam int SETTLE_CYC_MAX  = 15;

    // Filter and settle counters both top out at 15
    localparam int CNT_W = 4;

    function automatic bit params_legal(int sync_stages, int filt_len, int settle_cyc);
        return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
               (filt_len    >= FILT_LEN_MIN)    && (filt_len    <= FILT_LEN_MAX)    &&
               (settle_cyc  >= SETTLE_CYC_MIN)  && (settle_cyc  <= SETTLE_CYC_MAX);
    endfunction

endpackage

// File: rtl/od_pad_chan.sv
// rtl/od_pad_chan.sv - one open-drain channel: drive register, synchroniser, glitch filter, edges, contention
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   going_out_i        : 1 = release pad, 0 = drive low
//   pad_io             : chip pin
//   coming_in_o        : synchronised, filtered pad level
//   rise_p_o, fall_p_o : one-cycle pulses on coming_in_o changes
//   clr_contention_i   : clears the sticky contention flag
//   contention_o       : released pad sensed low after settling
module od_pad_chan
    import od_pad_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic going_out_i,
    inout  wire  pad_io,
    output logic coming_in_o,
    output logic rise_p_o,
    output logic fall_p_o,
    input  logic clr_contention_i,
    output logic contention_o
);

    logic                   drv_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       filt_cnt_q, filt_cnt_d;
    logic                   coming_q, coming_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       settle_q, settle_d;
    logic                   cont_q, cont_d;
    logic                   pad_sense;
    logic                   sync_val;
    logic                   cont_set;

    pad_bidirhe u_pad (
        .drive_low_i (~drv_q),
        .sense_o     (pad_sense),
        .pad_io      (pad_io)
    );

    assign sync_val = sync_q[SYNC_STAGES-1];

    // Filter: a new level is accepted on the cycle its run of disagreement
    // would reach FILT_LEN; any agreeing cycle restarts the count.
    always_comb begin
        filt_cnt_d = '0;
        coming_d   = coming_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (sync_val != coming_q) begin
            if (filt_cnt_q == CNT_W'(FILT_LEN - 1)) begin
                coming_d = sync_val;
                rise_d   = sync_val;
                fall_d   = ~sync_val;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Settle counter parks at SETTLE_CYC while driving, so a release starts
    // the countdown from the full value.
    always_comb begin
        settle_d = CNT_W'(SETTLE_CYC);
        if (drv_q) begin
            settle_d = (settle_q != '0) ? settle_q - 1'b1 : '0;
        end
    end

    // Set wins over clear; the live set term is also visible on the output
    // so the flag shows up on the first cycle checking is armed.
    assign cont_set = drv_q & (settle_q == '0) & ~coming_q;
    assign cont_d   = cont_set | (cont_q & ~clr_contention_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            drv_q      <= 1'b1;
            sync_q     <= '1;
            filt_cnt_q <= '0;
            coming_q   <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            settle_q   <= CNT_W'(SETTLE_CYC);
            cont_q     <= 1'b0;
        end else begin
            drv_q      <= going_out_i;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pad_sense};
            filt_cnt_q <= filt_cnt_d;
            coming_q   <= coming_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            settle_q   <= settle_d;
            cont_q     <= cont_d;
        end
    end

    assign coming_in_o  = coming_q;
    assign rise_p_o     = rise_q;
    assign fall_p_o     = fall_q;
    assign contention_o = cont_q | cont_set;

endmodule

// File: rtl/pad_bidirhe.sv
// rtl/pad_bidirhe.sv - open-drain bidirectional pad cell
// Ports:
//   drive_low_i : 1 = pull the pin low, 0 = high-Z
//   sense_o     : level seen on the pin
//   pad_io      : chip pin
module pad_bidirhe (
    input  logic drive_low_i,
    output logic sense_o,
    inout  wire  pad_io
);

    assign pad_io  = drive_low_i ? 1'b0 : 1'bz;
    assign sense_o = pad_io;

endmodule

// File: rtl/od_pad_bank.sv
// rtl/od_pad_bank.sv - bank of N_CH independent open-drain pad channels
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   going_out         : per channel 1 = release, 0 = drive low
//   pad               : chip pins
//   coming_in         : synchronised, filtered pad levels
//   rise_p, fall_p    : edge pulses of coming_in
//   clr_contention    : per-channel clear of contention
//   contention        : sticky released-but-low flags
module od_pad_bank
    import od_pad_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] going_out,
    inout  wire  [N_CH-1:0] pad,
    output logic [N_CH-1:0] coming_in,
    output logic [N_CH-1:0] rise_p,
    output logic [N_CH-1:0] fall_p,
    input  logic [N_CH-1:0] clr_contention,
    output logic [N_CH-1:0] contention
);

    if (!params_legal(SYNC_STAGES, FILT_LEN, SETTLE_CYC)) begin : g_bad_params
        $error("od_pad_bank: parameter out of legal range");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        od_pad_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .SETTLE_CYC  (SETTLE_CYC)
        ) u_chan (
            .clk              (clk),
            .reset            (reset),
            .going_out_i      (going_out[i]),
            .pad_io           (pad[i]),
            .coming_in_o      (coming_in[i]),
            .rise_p_o         (rise_p[i]),
            .fall_p_o         (fall_p[i]),
            .clr_contention_i (clr_contention[i]),
            .contention_o     (contention[i])
        );
    end

endmodule

// File: tb/tb_od_pad_bank.sv
// tb/tb_od_pad_bank.sv - scoreboard bench for od_pad_bank with directed and random stimulus
module tb_od_pad_bank;
    import od_pad_pkg::*;

    localparam int S  = SYNC_STAGES_DEF;
    localparam int F  = FILT_LEN_DEF;
    localparam int SC = SETTLE_CYC_DEF;
    localparam int LAST_CYC = 2070;

    logic       clk;
    logic       reset;
    logic [1:0] going_out;
    logic [1:0] clr_contention;
    logic [1:0] ext_low;
    wire  [1:0] pad;
    logic [1:0] coming_in, rise_p, fall_p, contention;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        logic [1:0] drv;
        logic [1:0] coming;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] cont;
    } exp_t;

    exp_t sb[$];

    od_pad_bank dut (
        .clk            (clk),
        .reset          (reset),
        .going_out      (going_out),
        .pad            (pad),
        .coming_in      (coming_in),
        .rise_p         (rise_p),
        .fall_p         (fall_p),
        .clr_contention (clr_contention),
        .contention     (contention)
    );

    pullup pu0 (pad[0]);
    pullup pu1 (pad[1]);
    assign pad[0] = ext_low[0] ? 1'b0 : 1'bz;
    assign pad[1] = ext_low[1] ? 1'b0 : 1'bz;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %b required %b", name, cyc, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0] m_drv, m_coming, m_sticky, m_sync;
    int         m_first_high[2];
    int         m_streak[2];
    logic [1:0] padq[$];

    function automatic int settle_of(logic d, int first_high, int t);
        if (!d) return SC;
        if (t - first_high >= SC) return 0;
        return SC - (t - first_high);
    endfunction

    task automatic model_step(input int t);
        logic [1:0] pad_t, setv;
        logic [1:0] n_drv, n_coming, n_rise, n_fall, n_sticky, n_sync;
        int         n_fh[2];
        int         n_streak[2];
        exp_t       e;
        pad_t  = m_drv & ~ext_low;
        n_rise = '0;
        n_fall = '0;
        for (int i = 0; i < 2; i++)
            setv[i] = m_drv[i] && (settle_of(m_drv[i], m_first_high[i], t) == 0) && !m_coming[i];
        if (reset) begin
            n_drv    = 2'b11;
            n_coming = 2'b11;
            n_sticky = 2'b00;
            n_sync   = 2'b11;
            padq.delete();
            for (int k = 0; k < S; k++) padq.push_back(2'b11);
            for (int i = 0; i < 2; i++) begin
                n_fh[i]     = t + 1;
                n_streak[i] = 0;
            end
        end else begin
            padq.push_front(pad_t);
            if (padq.size() > S) void'(padq.pop_back());
            n_sync = padq[S-1];
            for (int i = 0; i < 2; i++) begin
                n_drv[i]    = going_out[i];
                n_fh[i]     = (!m_drv[i] && going_out[i]) ? t + 1 : m_first_high[i];
                n_coming[i] = m_coming[i];
                n_streak[i] = 0;
                if (m_sync[i] != m_coming[i]) begin
                    n_streak[i] = m_streak[i] + 1;
                    if (n_streak[i] == F) begin
                        n_coming[i] = m_sync[i];
                        n_rise[i]   = m_sync[i];
                        n_fall[i]   = !m_sync[i];
                        n_streak[i] = 0;
                    end
                end
                n_sticky[i] = setv[i] | (m_sticky[i] & ~clr_contention[i]);
            end
        end
        m_drv    = n_drv;
        m_coming = n_coming;
        m_sticky = n_sticky;
        m_sync   = n_sync;
        for (int i = 0; i < 2; i++) begin
            m_first_high[i] = n_fh[i];
            m_streak[i]     = n_streak[i];
        end
        e.drv    = n_drv;
        e.coming = n_coming;
        e.rise   = n_rise;
        e.fall   = n_fall;
        for (int i = 0; i < 2; i++)
            e.cont[i] = n_sticky[i] |
                        (n_drv[i] && (settle_of(n_drv[i], n_fh[i], t + 1) == 0) && !n_coming[i]);
        sb.push_back(e);
    endtask

    initial begin
        m_drv    = 2'b11;
        m_coming = 2'b11;
        m_sticky = 2'b00;
        m_sync   = 2'b11;
        for (int i = 0; i < 2; i++) begin
            m_first_high[i] = 0;
            m_streak[i]     = 0;
        end
        for (int k = 0; k < S; k++) padq.push_back(2'b11);
        forever begin
            @(negedge clk);
            #1;
            if (cyc <= LAST_CYC) model_step(cyc);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pad",        pad,        e.drv & ~ext_low);
                chk("coming_in",  coming_in,  e.coming);
                chk("rise_p",     rise_p,     e.rise);
                chk("fall_p",     fall_p,     e.fall);
                chk("contention", contention, e.cont);
            end
        end
    end

    // ---------------- directed spot checks ----------------
    initial begin
        forever begin
            @(negedge clk);
            case (cyc)
                5:  begin
                        chk("rst_coming", coming_in, 2'b11);
                        chk("rst_cont", contention, 2'b00);
                        chk("rst_pad", pad, 2'b11);
                    end
                14: chk("ch0_before_fall", {1'b0, coming_in[0]}, 2'b01);
                15: begin
                        chk("ch0_fall", {1'b0, coming_in[0]}, 2'b00);
                        chk("ch0_fall_p", {1'b0, fall_p[0]}, 2'b01);
                    end
                16: chk("ch0_fall_p_once", {1'b0, fall_p[0]}, 2'b00);
                18: chk("ch1_glitch2_rejected", {1'b0, coming_in[1]}, 2'b01);
                20: chk("ch1_glitch3_pending", {1'b0, coming_in[1]}, 2'b01);
                21: chk("ch1_glitch3_accepted", {1'b0, coming_in[1]}, 2'b00);
                27: chk("ch1_pad_driven", {1'b0, pad[1]}, 2'b00);
                32: begin
                        chk("ch1_drive_seen", {1'b0, coming_in[1]}, 2'b00);
                        chk("ch1_no_cont", {1'b0, contention[1]}, 2'b00);
                    end
                34: chk("ch0_settling", {1'b0, contention[0]}, 2'b00);
                35: chk("ch0_cont_set", {1'b0, contention[0]}, 2'b01);
                39: chk("ch0_clr_while_low", {1'b0, contention[0]}, 2'b01);
                46: chk("ch0_sticky", {1'b0, contention[0]}, 2'b01);
                48: chk("ch0_cleared", {1'b0, contention[0]}, 2'b00);
                62: chk("pads_driven_in_reset", pad, 2'b00);
                63: begin
                        chk("post_rst_pad", pad, 2'b11);
                        chk("post_rst_coming", coming_in, 2'b11);
                        chk("post_rst_cont", contention, 2'b00);
                        chk("post_rst_edges", rise_p | fall_p, 2'b00);
                    end
                default: ;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cyc            = 0;
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        going_out      = 2'b11;
        clr_contention = 2'b00;
        ext_low        = 2'b00;
        while (cyc < LAST_CYC) begin
            @(posedge clk);
            #1;
            if (cyc < 66) begin
                reset             = (cyc < 5) || (cyc == 62);
                ext_low[0]        = (cyc >= 10) && (cyc < 40);
                ext_low[1]        = ((cyc >= 12) && (cyc < 14)) || ((cyc >= 16) && (cyc < 19));
                going_out[0]      = !((cyc >= 20) && (cyc < 30)) && !((cyc >= 58) && (cyc < 63));
                going_out[1]      = !((cyc >= 26) && (cyc < 50)) && !((cyc >= 58) && (cyc < 63));
                clr_contention[0] = (cyc == 22) || (cyc == 38) || (cyc == 47);
                clr_contention[1] = (cyc == 25);
            end else begin
                reset = ($urandom_range(299) == 0);
                for (int i = 0; i < 2; i++) begin
                    if ($urandom_range(7) == 0) ext_low[i]   = ~ext_low[i];
                    if ($urandom_range(9) == 0) going_out[i] = ~going_out[i];
                    clr_contention[i] = ($urandom_range(15) == 0);
                end
            end
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
